// File: rtl/clut_pkg.sv
// Shared widths, defaults and FSM encoding for the CLUT write-side controller.
package clut_pkg;
  localparam int DEF_COLOR_BITS    = 4;
  localparam int DEF_NUM_OF_COLORS = 16;
  localparam int DEF_LINE_SIZE     = 3;
  localparam int DEF_FIFO_DEPTH    = 4;

  localparam int ADDR_W  = $clog2(DEF_NUM_OF_COLORS);
  localparam int ENTRY_W = DEF_COLOR_BITS * DEF_LINE_SIZE;

  typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;
endpackage

// File: rtl/clut_wr_fifo.sv
// Small synchronous FIFO holding pending {addr,data} palette writes.
module clut_wr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic push_ok, pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // Depth is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end
endmodule

// File: rtl/clut_write_ctrl.sv
// CLUT write-port controller: queues CPU palette writes, drains them inside the
// blanking window when gated, and runs a bulk fill-every-entry clear sequence.
module clut_write_ctrl
  import clut_pkg::*;
#(
  parameter int COLOR_BITS    = DEF_COLOR_BITS,
  parameter int NUM_OF_COLORS = DEF_NUM_OF_COLORS,
  parameter int LINE_SIZE     = DEF_LINE_SIZE,
  parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH,
  localparam int A  = $clog2(NUM_OF_COLORS),
  localparam int W  = COLOR_BITS * LINE_SIZE,
  localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_req,
  input  logic [A-1:0]  wr_addr,
  input  logic [W-1:0]  wr_data,
  output logic          wr_ready,
  input  logic          clear_req,
  input  logic [W-1:0]  clear_color,
  input  logic          gate_en,
  input  logic          vblank,
  output logic          busy,
  output logic [CW-1:0] fifo_count,
  output logic          clut_we,
  output logic [A-1:0]  clut_addr_write,
  output logic [W-1:0]  clut_data_in
);
  localparam logic [A-1:0] LAST = A'(NUM_OF_COLORS - 1);

  state_t state, state_next;
  logic [A-1:0] idx, idx_d, addr_d, head_addr;
  logic [W-1:0] fill, fill_d, data_d, head_data;
  logic we_d, push, pop, win, full, empty;
  logic [CW-1:0] count_next;

  assign win        = !gate_en || vblank;
  assign wr_ready   = !full;
  assign push       = wr_req && !full;
  assign busy       = (state == CLEAR) || !empty;
  assign count_next = fifo_count + CW'(push) - CW'(pop);

  clut_wr_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(A + W)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   ({wr_addr, wr_data}),
    .dout  ({head_addr, head_data}),
    .count (fifo_count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      idx             <= '0;
      fill            <= '0;
      clut_we         <= 1'b0;
      clut_addr_write <= '0;
      clut_data_in    <= '0;
    end else begin
      state           <= state_next;
      idx             <= idx_d;
      fill            <= fill_d;
      clut_we         <= we_d;
      clut_addr_write <= addr_d;
      clut_data_in    <= data_d;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DRAIN: begin
        if (clear_req)             state_next = CLEAR;
        else if (count_next != '0) state_next = DRAIN;
        else                       state_next = IDLE;
      end
      CLEAR: begin
        if (win && idx == LAST) state_next = (count_next != '0) ? DRAIN : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // A clear start wins over a pop in the same cycle; queued writes then land after it.
  always_comb begin
    pop    = 1'b0;
    we_d   = 1'b0;
    addr_d = clut_addr_write;
    data_d = clut_data_in;
    idx_d  = idx;
    fill_d = fill;
    case (state)
      IDLE, DRAIN: begin
        if (clear_req) begin
          idx_d  = '0;
          fill_d = clear_color;
        end else if (win && !empty) begin
          pop    = 1'b1;
          we_d   = 1'b1;
          addr_d = head_addr;
          data_d = head_data;
        end
      end
      CLEAR: begin
        if (win) begin
          we_d   = 1'b1;
          addr_d = idx;
          data_d = fill;
          idx_d  = idx + A'(1);
        end
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_clut_write_ctrl.sv
// Scoreboard bench for clut_write_ctrl: a queue-based reference model predicts every
// CLUT write, and a negedge monitor compares what the DUT presents.
module tb_clut_write_ctrl;
  import clut_pkg::*;

  localparam int N     = DEF_NUM_OF_COLORS;
  localparam int DEPTH = DEF_FIFO_DEPTH;

  logic clk = 1'b0, reset = 1'b1, wr_req = 1'b0, clear_req = 1'b0;
  logic gate_en = 1'b0, vblank = 1'b0;
  logic [ADDR_W-1:0]  wr_addr = '0;
  logic [ENTRY_W-1:0] wr_data = '0, clear_color = '0;
  logic wr_ready, busy, clut_we;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [ADDR_W-1:0]  clut_addr_write;
  logic [ENTRY_W-1:0] clut_data_in;

  always #5 clk = ~clk;

  clut_write_ctrl dut (
    .clk(clk), .reset(reset), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready), .clear_req(clear_req), .clear_color(clear_color),
    .gate_en(gate_en), .vblank(vblank), .busy(busy), .fifo_count(fifo_count),
    .clut_we(clut_we), .clut_addr_write(clut_addr_write), .clut_data_in(clut_data_in)
  );

  int n_checks = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [ENTRY_W-1:0] data;
  } wr_t;

  // Reference model: pending writes, clear progress, expected-write scoreboard.
  wr_t pend[$];
  wr_t expq[$];
  bit  m_clearing = 0, exp_we = 0, started = 0;
  int  m_idx = 0;
  logic [ENTRY_W-1:0] m_fill = '0;
  logic [ENTRY_W-1:0] model_ram [N];
  logic [ENTRY_W-1:0] dut_ram   [N];

  always @(posedge clk) begin
    bit  win, acc;
    wr_t w;
    started = 1;
    win    = !gate_en || vblank;
    acc    = wr_req && (pend.size() != DEPTH);
    exp_we = 0;
    if (reset) begin
      pend.delete();
      m_clearing = 0;
      m_idx      = 0;
    end else begin
      if (m_clearing) begin
        if (win) begin
          w.addr = ADDR_W'(m_idx);
          w.data = m_fill;
          expq.push_back(w);
          exp_we = 1;
          model_ram[m_idx] = m_fill;
          m_idx++;
          if (m_idx == N) m_clearing = 0;
        end
      end else if (clear_req) begin
        m_clearing = 1;
        m_idx      = 0;
        m_fill     = clear_color;
      end else if (win && pend.size() != 0) begin
        w = pend.pop_front();
        expq.push_back(w);
        exp_we = 1;
        model_ram[w.addr] = w.data;
      end
      if (acc) begin
        w.addr = wr_addr;
        w.data = wr_data;
        pend.push_back(w);
      end
    end
  end

  always @(negedge clk) begin
    wr_t w;
    if (started) begin
      check("clut_we", 32'(clut_we), 32'(exp_we));
      if (clut_we === 1'b1) dut_ram[clut_addr_write] = clut_data_in;
      if (exp_we && expq.size() != 0) begin
        w = expq.pop_front();
        if (clut_we === 1'b1) begin
          check("clut_addr", 32'(clut_addr_write), 32'(w.addr));
          check("clut_data", 32'(clut_data_in), 32'(w.data));
        end
      end
      check("fifo_count", 32'(fifo_count), 32'(pend.size()));
      check("wr_ready", 32'(wr_ready), 32'(pend.size() != DEPTH));
      check("busy", 32'(busy), 32'(m_clearing || pend.size() != 0));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [ENTRY_W-1:0] c1;

  initial begin
    for (int i = 0; i < N; i++) begin
      model_ram[i] = '0;
      dut_ram[i]   = '0;
    end
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    check("rst_addr", 32'(clut_addr_write), 32'd0);
    check("rst_data", 32'(clut_data_in), 32'd0);

    // Single ungated write
    gate_en = 1'b0; wr_req = 1'b1; wr_addr = 4'd3; wr_data = 12'hF00;
    tick(1);
    wr_req = 1'b0;
    tick(4);
    check("s1_ram3", 32'(dut_ram[3]), 32'h0F00);
    check("s1_busy", 32'(busy), 32'd0);

    // Fill FIFO while gated closed, then open the window
    gate_en = 1'b1; vblank = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wr_req = 1'b1; wr_addr = ADDR_W'(i + 8); wr_data = ENTRY_W'($urandom);
      if (i == 4) check("s2_full_ready", 32'(wr_ready), 32'd0);
      tick(1);
    end
    wr_req = 1'b0;
    tick(2);
    check("s2_count", 32'(fifo_count), 32'd4);
    vblank = 1'b1;
    tick(6);

    // Toggling vblank during a drain
    for (int c = 0; c < 20; c++) begin
      wr_req  = (c < 7);
      wr_addr = ADDR_W'($urandom);
      wr_data = ENTRY_W'($urandom);
      vblank  = ((c >> 1) & 1) != 0;
      tick(1);
    end
    wr_req = 1'b0; vblank = 1'b1;
    tick(6);

    // Clear with a write queued mid-sequence
    gate_en = 1'b0; clear_req = 1'b1; clear_color = 12'h00F;
    tick(1);
    clear_req = 1'b0;
    tick(4);
    wr_req = 1'b1; wr_addr = 4'd5; wr_data = 12'h0F0;
    tick(1);
    wr_req = 1'b0;
    tick(20);
    check("s4_ram5", 32'(dut_ram[5]), 32'h00F0);
    check("s4_ram0", 32'(dut_ram[0]), 32'h000F);
    check("s4_ram15", 32'(dut_ram[15]), 32'h000F);

    // Clear paused by vblank after index 7; second clear_req ignored
    gate_en = 1'b1; vblank = 1'b1; clear_req = 1'b1; c1 = 12'hA5C; clear_color = c1;
    tick(1);
    clear_req = 1'b0;
    tick(8);
    vblank = 1'b0; clear_req = 1'b1; clear_color = 12'h3C3;
    tick(3);
    clear_req = 1'b0; vblank = 1'b1;
    tick(14);
    check("s5_ram8", 32'(dut_ram[8]), 32'(c1));
    check("s5_ram0", 32'(dut_ram[0]), 32'(c1));
    check("s5_busy", 32'(busy), 32'd0);

    // Reset mid-clear with two writes queued
    gate_en = 1'b0; clear_req = 1'b1; clear_color = 12'h123;
    tick(1);
    clear_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wr_req = 1'b1; wr_addr = ADDR_W'(i); wr_data = ENTRY_W'($urandom);
      tick(1);
    end
    wr_req = 1'b0;
    tick(7);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("s6_we", 32'(clut_we), 32'd0);
    check("s6_count", 32'(fifo_count), 32'd0);
    check("s6_ready", 32'(wr_ready), 32'd1);
    check("s6_busy", 32'(busy), 32'd0);
    tick(5);

    // Randomized traffic
    for (int c = 0; c < 2000; c++) begin
      reset     = ($urandom_range(499) == 0);
      clear_req = ($urandom_range(59) == 0);
      clear_color = ENTRY_W'($urandom);
      wr_req  = $urandom_range(1) != 0;
      wr_addr = ADDR_W'($urandom);
      wr_data = ENTRY_W'($urandom);
      if ($urandom_range(99) == 0) gate_en = ~gate_en;
      if ($urandom_range(3) == 0)  vblank  = ~vblank;
      tick(1);
    end
    reset = 1'b0; clear_req = 1'b0; wr_req = 1'b0; gate_en = 1'b0;
    tick(30);

    check("end_scoreboard_empty", 32'(expq.size()), 32'd0);
    for (int i = 0; i < N; i++) check($sformatf("ram[%0d]", i), 32'(dut_ram[i]), 32'(model_ram[i]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
